// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// logic_unit_pipe : registered 8-function bitwise logic unit with running
//                   accumulate and a 2-entry output buffer.   Rev 1.0
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic             y_any
);

  localparam logic [2:0] c_OP_AND  = 3'd0;
  localparam logic [2:0] c_OP_OR   = 3'd1;
  localparam logic [2:0] c_OP_XOR  = 3'd2;
  localparam logic [2:0] c_OP_NAND = 3'd3;
  localparam logic [2:0] c_OP_NOR  = 3'd4;
  localparam logic [2:0] c_OP_XNOR = 3'd5;
  localparam logic [2:0] c_OP_NOTA = 3'd6;
  localparam logic [2:0] c_OP_PASS = 3'd7;

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] buf_q [2];

  logic             w_push;
  logic             w_pop;
  logic             w_tail;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_res;

  assign in_ready  = (count_q != c_FULL);
  assign out_valid = (count_q != c_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Write slot sits one past the head when one entry is already held.
  assign w_tail    = head_q ^ count_q[0];

  always_comb begin
    w_opb = acc ? acc_q : b;
    w_res = a;
    if (!(acc && acc_clr)) begin
      case (op)
        c_OP_AND:  w_res = a & w_opb;
        c_OP_OR:   w_res = a | w_opb;
        c_OP_XOR:  w_res = a ^ w_opb;
        c_OP_NAND: w_res = ~(a & w_opb);
        c_OP_NOR:  w_res = ~(a | w_opb);
        c_OP_XNOR: w_res = ~(a ^ w_opb);
        c_OP_NOTA: w_res = ~a;
        c_OP_PASS: w_res = a;
        default:   w_res = a;
      endcase
    end
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    head_d  = head_q ^ w_pop;
    if (w_push && acc) begin
      acc_d = w_res;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= c_EMPTY;
      head_q  <= 1'b0;
      acc_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      acc_q   <= acc_d;
      if (w_push) begin
        buf_q[w_tail] <= w_res;
      end
    end
  end

  assign y     = buf_q[head_q];
  assign y_all = &y;
  assign y_any = |y;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// Self-checking bench for logic_unit_pipe: directed plan plus random traffic
// against a queue-based reference model.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         acc = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         in_ready, out_valid, y_all, y_any;
  logic [W-1:0] y;

  int           n_assert = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m = '0;
  logic [W-1:0] sweep_tbl [8];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_all(y_all), .y_any(y_any)
  );

  function automatic logic [W-1:0] gate(input logic [2:0] f, input logic [W-1:0] x,
                                        input logic [W-1:0] z);
    case (f)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x & z);
      3'd4:    return ~(x | z);
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] h;
    check_b({tag, ".out_valid"}, out_valid, exp_q.size() != 0);
    check_b({tag, ".in_ready"}, in_ready, exp_q.size() != 2);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check_v({tag, ".y"}, y, h);
      check_b({tag, ".y_all"}, y_all, h == {W{1'b1}});
      check_b({tag, ".y_any"}, y_any, h != '0);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 ns later.
  task automatic beat(input logic v, input logic [2:0] f, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic ac, input logic clr,
                      input logic ordy, input string tag);
    logic         take, pop;
    logic [W-1:0] r;
    in_valid = v; op = f; a = av; b = bv; acc = ac; acc_clr = clr; out_ready = ordy;
    @(posedge clk);
    take = v && (exp_q.size() < 2);
    pop  = ordy && (exp_q.size() > 0);
    r    = '0;
    if (take) begin
      r = (ac && clr) ? av : gate(f, av, ac ? acc_m : bv);
      if (ac) acc_m = r;
    end
    if (pop) void'(exp_q.pop_front());
    if (take) exp_q.push_back(r);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    sweep_tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_b("rst.out_valid", out_valid, 1'b0);
    check_b("rst.in_ready", in_ready, 1'b1);
    check_v("rst.y", y, 8'h00);
    check_b("rst.y_all", y_all, 1'b0);
    check_b("rst.y_any", y_any, 1'b0);
    rst_n = 1'b1;

    // All eight functions at full throughput
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0, 1'b1, "sweep");
      check_v("sweep.const", y, sweep_tbl[i]);
    end
    beat(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, "all_ones");
    check_b("all_ones.y_all", y_all, 1'b1);
    beat(1'b1, 3'd0, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, "zero");
    check_b("zero.y_any", y_any, 1'b0);
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "drain0");

    // Accumulate chain
    beat(1'b1, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, "acc1");
    check_v("acc1.const", y, 8'hFF);
    beat(1'b1, 3'd0, 8'hF3, 8'h00, 1'b1, 1'b0, 1'b1, "acc2");
    check_v("acc2.const", y, 8'hF3);
    beat(1'b1, 3'd0, 8'h3F, 8'h00, 1'b1, 1'b0, 1'b1, "acc3");
    check_v("acc3.const", y, 8'h33);
    beat(1'b1, 3'd2, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, "acc4");
    check_v("acc4.const", y, 8'h3C);
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "drain1");

    // Back-pressure
    beat(1'b1, 3'd7, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, "bp1");
    beat(1'b1, 3'd7, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, "bp2");
    beat(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, "bp3");
    check_b("bp3.in_ready", in_ready, 1'b0);
    check_v("bp3.y_hold", y, 8'h11);
    beat(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1, "bp_pop");
    check_b("bp_pop.in_ready", in_ready, 1'b1);
    check_v("bp_pop.y", y, 8'h22);
    beat(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, "bp_take");
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "bp_d1");
    check_v("bp_d1.y", y, 8'h33);
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "bp_d2");

    // Simultaneous push/pop at count=1
    beat(1'b1, 3'd2, 8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0, "pp_fill");
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 3'd2, W'(i * 17), 8'hA5, 1'b0, 1'b0, 1'b1, "pp");
      check_b("pp.out_valid", out_valid, 1'b1);
    end
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "pp_drain");

    // Reset mid-stream with count=2, accumulator 0x33
    beat(1'b1, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, "mr1");
    beat(1'b1, 3'd0, 8'hF3, 8'h00, 1'b1, 1'b0, 1'b1, "mr2");
    beat(1'b1, 3'd0, 8'h3F, 8'h00, 1'b1, 1'b0, 1'b0, "mr3");
    check_b("mr3.in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_b("mrst.out_valid", out_valid, 1'b0);
    check_v("mrst.y", y, 8'h00);
    check_b("mrst.y_all", y_all, 1'b0);
    check_b("mrst.y_any", y_any, 1'b0);
    check_b("mrst.in_ready", in_ready, 1'b1);
    exp_q.delete();
    acc_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b1, 3'd1, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b1, "post_rst");
    check_v("post_rst.const", y, 8'h05);

    // acc_clr ignored without acc
    beat(1'b1, 3'd0, 8'h50, 8'h00, 1'b1, 1'b1, 1'b1, "clr_seed");
    beat(1'b1, 3'd0, 8'hAA, 8'h0F, 1'b0, 1'b1, 1'b1, "clr_noacc");
    check_v("clr_noacc.const", y, 8'h0A);
    beat(1'b1, 3'd1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, "clr_follow");
    check_v("clr_follow.const", y, 8'h51);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      beat(1'($urandom_range(0, 3) != 0), 3'($urandom), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) != 0), "rand");
    end
    repeat (3) beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit: the next generation of the team's single-bit two-input gate cells.
- Operands are WIDTH bits wide. A 3-bit opcode selects one of eight gate functions.
- An accumulate mode chains each result into the next beat (running AND/OR/XOR).
- Sits on a valid/ready stream. A 2-entry output buffer gives full throughput under back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored when acc=1).
- op  in  3  function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A.
- acc  in  1  accumulate mode for this beat.
- acc_clr  in  1  start a new accumulation chain (honoured only with acc=1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  WIDTH  result.
- y_all  out  1  AND-reduction of y.
- y_any  out  1  OR-reduction of y.

Behaviour:
- Handshakes:
  - Input beat accepted when in_valid & in_ready at a rising clk edge.
  - Output beat consumed when out_valid & out_ready.
- Function of an accepted beat:
  - Operand B is b if acc=0, else acc_reg.
  - Result = op(a, B), computed bitwise on all WIDTH bits.
  - Ops 6 and 7 ignore B.
- Accumulator (acc_reg, WIDTH bits):
  - On an accepted beat with acc=1 and acc_clr=0: acc_reg <= result.
  - On an accepted beat with acc=1 and acc_clr=1: result is forced to a regardless of op, and acc_reg <= a.
  - acc=0: acc_reg unchanged, acc_clr ignored.
  - acc_reg is not visible on any port.
- Buffer: 2-entry FIFO of results with count 0..2.
  - in_ready = (count != 2), combinational from the registered count.
  - out_valid = (count != 0). y is the head entry.
  - y_all and y_any are combinational from y.
- Latency: a beat accepted at edge N with the buffer empty appears on y with out_valid=1 after edge N. That is one cycle, with no combinational path from a/b to y.
- Count update per edge: +1 on accept only, -1 on consume only, unchanged on both or neither.
  - count=2: no accept is possible. A consume frees a slot; in_ready rises the following cycle.
  - count=1 with simultaneous accept and consume: the head advances to the new result, count stays 1, and out_valid stays high.
- Order: results emerge in acceptance order. No beat is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, y holds stable.
- Reset (async, any time including mid-stream):
  - count=0, acc_reg=0, all buffer entries=0.
  - out_valid=0, y=0, y_all=0, y_any=0, in_ready=1.
  - In-flight beats are discarded.
  - After deassertion, the first accepted beat with acc=1 and acc_clr=0 uses acc_reg=0.
- Inputs are don't-care when in_valid=0. acc and acc_clr have no effect without an accepted beat.

Test Plan:
- WIDTH=8, out_ready=1: a=0xF0, b=0xCC through ops 0..7.
  - Required y sequence: 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0x0F, 0xF0.
  - Each result one cycle after acceptance, full throughput.
  - y_all=1 only for op 0 with a=b=0xFF; y_any=0 only when y=0x00.
- Accumulate, op=0 (AND):
  - Beats: a=0xFF with acc_clr=1, then a=0xF3, then a=0x3F (acc=1 on all three).
  - Required y: 0xFF, 0xF3, 0x33. Then op=2 (XOR), acc=1, a=0x0F gives y=0x3C.
- Back-pressure: out_ready=0 with 3 beats offered.
  - Exactly 2 accepted; in_ready=0 thereafter and y holds the first result.
  - out_ready=1 for one cycle: first result consumed, in_ready=1 next cycle.
  - Third beat then accepted; order preserved.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, out_valid never drops, all 10 results correct and in order.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously with count=2 and acc_reg=0x33. out_valid, y, y_all, y_any drop to 0 immediately, and in_ready=1.
  - After release, acc=1, op=1 (OR), a=0x05 gives y=0x05.
- acc_clr with acc=0: op=0, a=0xAA, b=0x0F, acc_clr=1 gives y=0x0A, and acc_reg is unchanged (checked by a following acc=1 OR beat).
